// File: rtl/decode_queue.sv
// decode_queue: in-order instruction queue between decode and issue.
// It holds DEPTH entries of (instruction pack, PC) and uses valid/ready on
// both sides. A redirect flush empties the queue in one cycle.
// Optional build macro: DECODE_QUEUE_BYPASS_EN. When it is defined, an
// entry offered to an empty queue is presented on the dequeue side in the
// same cycle.

package com_pkg;

    typedef enum logic [2:0] {
        ALU     = 3'd0,
        BRANCH  = 3'd1,
        LOAD    = 3'd2,
        STORE   = 3'd3,
        ILLEGAL = 3'd7
    } inst_class_t;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        AND = 4'd2,
        OR  = 4'd3,
        BEQ = 4'd4,
        LW  = 4'd5,
        SW  = 4'd6,
        IL  = 4'd15
    } func_t;

    typedef struct packed {
        logic        illegal;
        inst_class_t inst_class;
        func_t       func;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } instruction_pack_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] redirect;
        logic        jump;
        logic        taken;
    } flush_t;

endpackage

module decode_queue #(
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = DEPTH - 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  com_pkg::flush_t               flush_i,
    input  logic                          enq_valid_i,
    output logic                          enq_ready_o,
    input  com_pkg::instruction_pack_t    enq_pack_i,
    input  logic [31:0]                   enq_pc_i,
    output logic                          deq_valid_o,
    input  logic                          deq_ready_i,
    output com_pkg::instruction_pack_t    deq_pack_o,
    output logic [31:0]                   deq_pc_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o,
    output logic                          almost_full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

    // Storage: deliberately not reset, only the pointers and the count are.
    com_pkg::instruction_pack_t pack_mem_q [DEPTH];
    logic [31:0]                pc_mem_q   [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          afull_q, afull_d;

    logic flush_s;
    logic empty_s;
    logic enq_fire_s;
    logic deq_fire_s;
    logic byp_take_s;
    logic wr_s;
    logic rd_s;

    assign flush_s    = flush_i.valid;
    assign empty_s    = (count_q == {CW{1'b0}});
    assign enq_ready_o = (count_q < DEPTH_C) && !flush_s;
    assign enq_fire_s = enq_valid_i && enq_ready_o;
    assign deq_fire_s = deq_valid_o && deq_ready_i;

`ifdef DECODE_QUEUE_BYPASS_EN
    // Bypass build: an empty queue forwards the producer straight through.
    always_comb begin
        if (empty_s) begin
            deq_valid_o = enq_valid_i && !flush_s;
        end else begin
            deq_valid_o = !flush_s;
        end
    end
    // An entry consumed in the same cycle it arrives is never written.
    assign byp_take_s = empty_s && enq_fire_s && deq_ready_i;
`else
    // Default build: the head is only ever taken from storage.
    always_comb begin
        deq_valid_o = !empty_s && !flush_s;
    end
    assign byp_take_s = 1'b0;
`endif

    assign wr_s = enq_fire_s && !byp_take_s;
    assign rd_s = deq_fire_s && !byp_take_s;

    // Head selection: forwarded entry when empty, stored head otherwise, zero when idle.
    always_comb begin
        deq_pack_o = '0;
        deq_pc_o   = 32'h0000_0000;
        if (deq_valid_o) begin
            if (empty_s) begin
                deq_pack_o = enq_pack_i;
                deq_pc_o   = enq_pc_i;
            end else begin
                deq_pack_o = pack_mem_q[rptr_q];
                deq_pc_o   = pc_mem_q[rptr_q];
            end
        end else begin
            deq_pack_o = '0;
            deq_pc_o   = 32'h0000_0000;
        end
    end

    // Next-state for pointers, occupancy and the almost-full flag.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_s) begin
            wptr_d  = {AW{1'b0}};
            rptr_d  = {AW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            if (wr_s) begin
                wptr_d = wptr_q + AW'(1);
            end else begin
                wptr_d = wptr_q;
            end
            if (rd_s) begin
                rptr_d = rptr_q + AW'(1);
            end else begin
                rptr_d = rptr_q;
            end
            case ({wr_s, rd_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        afull_d = (count_d >= AFULL_C);
    end

    // Control state registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= {AW{1'b0}};
            rptr_q  <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
            afull_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            afull_q <= afull_d;
        end
    end

    // Entry storage write on an accepted, non-bypassed enqueue.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            pack_mem_q[wptr_q] <= enq_pack_i;
            pc_mem_q[wptr_q]   <= enq_pc_i;
        end
    end

    assign count_o       = count_q;
    assign almost_full_o = afull_q;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue (DEPTH=4, AFULL_LVL=3).
module tb_decode_queue;

    import com_pkg::*;

`ifdef DECODE_QUEUE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    flush_t            fl_s;
    logic              enq_valid;
    logic              enq_ready;
    instruction_pack_t enq_pack;
    logic [31:0]       enq_pc;
    logic              deq_valid;
    logic              deq_ready;
    instruction_pack_t deq_pack;
    logic [31:0]       deq_pc;
    logic [2:0]        count;
    logic              afull;

    int checks = 0;
    int errors = 0;

    typedef struct {
        instruction_pack_t pack;
        logic [31:0]       pc;
    } sb_t;
    sb_t sb [$];

    typedef struct {
        logic        ev;
        logic [31:0] pc;
        logic        dr;
        logic [2:0]  exp_cnt;
        logic        exp_af;
        logic        exp_er;
        logic        exp_dv;
    } vec_t;
    vec_t vecs [11];

    decode_queue #(.DEPTH(4), .AFULL_LVL(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (fl_s),
        .enq_valid_i   (enq_valid),
        .enq_ready_o   (enq_ready),
        .enq_pack_i    (enq_pack),
        .enq_pc_i      (enq_pc),
        .deq_valid_o   (deq_valid),
        .deq_ready_i   (deq_ready),
        .deq_pack_o    (deq_pack),
        .deq_pc_o      (deq_pc),
        .count_o       (count),
        .almost_full_o (afull)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic instruction_pack_t mk_pack(input logic [31:0] pc, input logic ill);
        instruction_pack_t p;
        p = '0;
        p.rd  = pc[6:2];
        p.rs1 = pc[11:7];
        p.rs2 = ~pc[6:2];
        p.imm = ~pc;
        if (ill) begin
            p.illegal    = 1'b1;
            p.inst_class = ILLEGAL;
            p.func       = IL;
        end else begin
            p.illegal    = 1'b0;
            p.inst_class = ALU;
            p.func       = ADD;
        end
        return p;
    endfunction

    task automatic drive(input logic ev, input logic [31:0] pc, input logic dr,
                         input logic fl, input logic ill);
        enq_valid   = ev;
        enq_pc      = pc;
        enq_pack    = mk_pack(pc, ill);
        deq_ready   = dr;
        fl_s.valid  = fl;
        fl_s.redirect = $urandom;
        fl_s.jump   = 1'b1;
        fl_s.taken  = 1'b1;
    endtask

    task automatic chk_state(input string tag, input logic [2:0] c, input logic af,
                             input logic er, input logic dv);
        chk({tag, "_count"}, 64'(count), 64'(c));
        chk({tag, "_afull"}, 64'(afull), 64'(af));
        chk({tag, "_enq_ready"}, 64'(enq_ready), 64'(er));
        chk({tag, "_deq_valid"}, 64'(deq_valid), 64'(dv));
    endtask

    // Scoreboard: push on accepted enqueue, compare head while valid, pop on dequeue.
    always @(negedge clk) begin
        if (!rst_n || fl_s.valid) begin
            sb.delete();
            chk("idle_pc_zero", 64'(deq_pc), 64'h0);
        end else begin
            if (enq_valid && enq_ready) begin
                sb.push_back('{pack: enq_pack, pc: enq_pc});
            end
            if (deq_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_valid", 64'(deq_valid), 64'h0);
                end else begin
                    chk("head_pc", 64'(deq_pc), 64'(sb[0].pc));
                    chk("head_pack", 64'(deq_pack), 64'(sb[0].pack));
                    if (deq_ready) begin
                        void'(sb.pop_front());
                    end
                end
            end else begin
                chk("idle_pc_zero", 64'(deq_pc), 64'h0);
                chk("idle_pack_zero", 64'(deq_pack), 64'h0);
            end
        end
    end

    initial begin
        // ev, pc, dr, count, afull, enq_ready, deq_valid (state before the edge)
        vecs[0]  = '{1'b1, 32'h100, 1'b0, 3'd0, 1'b0, 1'b1, BYP};
        vecs[1]  = '{1'b1, 32'h104, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{1'b1, 32'h108, 1'b0, 3'd2, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 32'h10C, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 32'h110, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 32'h110, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 32'h110, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 32'h0,   1'b1, 3'd3, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 32'h0,   1'b1, 3'd2, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 32'h0,   1'b1, 3'd1, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 32'h0,   1'b0, 3'd0, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk_state("reset", 3'd0, 1'b0, 1'b1, 1'b0);
        chk("reset_pack", 64'(deq_pack), 64'h0);

        // Fill to full, hold off a fifth entry, then drain across the wrap.
        foreach (vecs[i]) begin
            @(posedge clk);
            #1 drive(vecs[i].ev, vecs[i].pc, vecs[i].dr, 1'b0, 1'b0);
            #1 chk_state($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_af,
                         vecs[i].exp_er, vecs[i].exp_dv);
        end

        // Preload two entries, then stream one in and one out per cycle.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1 drive(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 drive(1'b1, 32'h308 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
            #1 chk_state($sformatf("stream%0d", i), 3'd2, 1'b0, 1'b1, 1'b1);
        end

        // One more enqueue with no dequeue brings the count to 3, then flush.
        @(posedge clk);
        #1 drive(1'b1, 32'h380, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 drive(1'b1, 32'hDEAD_0000, 1'b1, 1'b1, 1'b0);
        #1 chk_state("flush_cycle", 3'd3, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 drive(1'b1, 32'h400, 1'b0, 1'b0, 1'b1);
        #1 chk("after_flush_count", 64'(count), 64'h0);
        chk("after_flush_afull", 64'(afull), 64'h0);

        // Illegal entry travels like any other; then a normal one behind it.
        @(posedge clk);
        #1 drive(1'b1, 32'h404, 1'b1, 1'b0, 1'b0);
        #1 chk("illegal_head_pc", 64'(deq_pc), 64'h400);
        chk("illegal_head_flag", 64'(deq_pack.illegal), 64'h1);
        chk("illegal_head_class", 64'(deq_pack.inst_class), 64'(ILLEGAL));
        chk("illegal_head_func", 64'(deq_pack.func), 64'(IL));
        @(posedge clk);
        #1 drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1 chk_state("drained", 3'd0, 1'b0, 1'b1, 1'b0);

        // Empty queue with producer and consumer both active.
        @(posedge clk);
        #1 drive(1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
        #1 chk("empty_offer_valid", 64'(deq_valid), 64'(BYP));
        chk("empty_offer_pc", 64'(deq_pc), BYP ? 64'h200 : 64'h0);
        @(posedge clk);
        #1 drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        #1 chk("empty_offer_count", 64'(count), BYP ? 64'h0 : 64'h1);
        @(posedge clk);
        #1 drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1 chk("empty_offer_drained", 64'(count), 64'h0);

        // Asynchronous reset mid-operation clears state without a clock edge.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 drive(1'b1, 32'h500 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
        end
        @(posedge clk);
        #1 drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1 chk("pre_reset_count", 64'(count), 64'h3);
        rst_n = 1'b0;
        #1 chk_state("async_reset", 3'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2 chk_state("post_reset", 3'd0, 1'b0, 1'b1, 1'b0);
        chk("sb_empty_end", 64'(sb.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised instruction queue between decode and issue. It buffers `com_pkg::instruction_pack_t` entries together with their PC, using valid/ready handshakes on both sides. A `com_pkg::flush_t` redirect discards every buffered entry in one cycle. It generalises the single-slot decode→issue hand-off to a configurable depth, and adds occupancy reporting and an optional empty-queue bypass.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, ≥ 2.
- `AFULL_LVL`, DEPTH-1: `almost_full_o` asserts when count ≥ this value; legal range 1..DEPTH.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush_i` in `$bits(flush_t)`: redirect from the back end; only `.valid` is consumed.
- `enq_valid_i` in 1: decode presents an entry.
- `enq_ready_o` out 1: queue accepts the entry this cycle.
- `enq_pack_i` in `$bits(instruction_pack_t)`: entry payload.
- `enq_pc_i` in 32: entry PC.
- `deq_valid_o` out 1: head entry available.
- `deq_ready_i` in 1: issue consumes the head.
- `deq_pack_o` out `$bits(instruction_pack_t)`: head payload; '0 when `deq_valid_o`=0.
- `deq_pc_o` out 32: head PC; '0 when `deq_valid_o`=0.
- `count_o` out `$clog2(DEPTH+1)`: current occupancy.
- `almost_full_o` out 1: count ≥ `AFULL_LVL`.

## Operation
- Storage is a flop array of DEPTH × (pack + PC). The array is not reset.
- Pointers:
  - Write and read pointers are `$clog2(DEPTH)` bits and wrap naturally from DEPTH-1 to 0.
  - Occupancy is a separate counter, 0..DEPTH.
- Enqueue fires when `enq_valid_i && enq_ready_o`. It writes mem[wptr] and increments wptr.
- Dequeue fires when `deq_valid_o && deq_ready_i`. It increments rptr.
- Count update: +1 on enqueue only, −1 on dequeue only, unchanged when both or neither fire.
- Ready, valid and head:
  - `enq_ready_o` = (count < DEPTH) && !flush_i.valid.
  - There is no full-queue pass-through: a dequeue while full does not free a slot in the same cycle.
  - `deq_valid_o` = (count != 0) && !flush_i.valid.
  - The head is read combinationally from mem[rptr].
- Flush: while `flush_i.valid`=1, no enqueue or dequeue can fire. At the next edge, wptr, rptr and count are cleared to 0. The redirect address, jump and taken fields are ignored.
- Entries with `illegal`=1 or `inst_class`=ILLEGAL are queued and delivered like any other entry; the exception is raised downstream.
- Entries leave strictly in order; no reordering or dropping except on flush.
- Input stability: a stalled producer must hold `enq_*` stable while `enq_valid_i`=1. The queue holds `deq_*` stable while `deq_valid_o`=1 and `deq_ready_i`=0, except during a flush.

## Timing
- Reset values, asynchronous on `rst_n`=0: wptr=rptr=count=0, so `deq_valid_o`=0, `deq_pack_o`='0, `deq_pc_o`='0, `count_o`=0, `almost_full_o`=0. `enq_ready_o`=1 whenever `flush_i.valid`=0.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Enqueue→dequeue latency is 1 cycle: an entry accepted at edge N is visible on `deq_*` after edge N.
- Throughput is one enqueue and one dequeue per cycle when 0 < count < DEPTH.
- Full (count=DEPTH): `enq_ready_o`=0. A dequeue at edge N reopens `enq_ready_o` after edge N.
- Empty (count=0): `deq_valid_o`=0 (see the bypass option under Configuration).
- `count_o` and `almost_full_o` are derived from registered state only. They have no combinational path from the inputs.
- A flush in the same cycle as `enq_valid_i`=1 drops that entry; the producer sees `enq_ready_o`=0.

## Configuration
- `DECODE_QUEUE_BYPASS_EN` defined: when count=0 and `flush_i.valid`=0, `deq_valid_o` = `enq_valid_i`, and `deq_pack_o`/`deq_pc_o` are driven from `enq_*`, giving 0-cycle latency.
  - If `deq_ready_i`=1 in that cycle, the entry is consumed and not written; count stays 0.
  - Otherwise the entry is written as a normal enqueue.
  - This creates a combinational path from `enq_*` to `deq_*`.
- `DECODE_QUEUE_BYPASS_EN` not defined: no enq→deq combinational path, and latency is always ≥1 cycle.

## Test plan
- Reset with `rst_n` low for 2 cycles, then released → `deq_valid_o`=0, `count_o`=0, `enq_ready_o`=1, `almost_full_o`=0, `deq_pack_o`='0.
- DEPTH=4, `deq_ready_i`=0, enqueue PCs 0x100, 0x104, 0x108, 0x10C on consecutive cycles:
  - `count_o` steps 1→4.
  - `almost_full_o` rises after the 3rd enqueue.
  - `enq_ready_o`=0 after the 4th.
  - A 5th entry (0x110) is held off.
- Then `deq_ready_i`=1 for 4 cycles → PCs appear in order 0x100..0x10C. 0x110 is accepted one cycle after the first dequeue. No entry is lost across the wptr/rptr wrap.
- Continuous `enq_valid_i`/`deq_ready_i` for 20 cycles from count=2 → exactly one entry in and one out per cycle, and `count_o` stays at 2.
- Count=3 with `flush_i.valid`=1 for one cycle while `enq_valid_i`=1:
  - `deq_valid_o`=0 and `enq_ready_o`=0 in that cycle.
  - `count_o`=0 on the next cycle.
  - The next enqueued entry is the next one dequeued.
- Entry with `illegal`=1 and `inst_class`=ILLEGAL, func=IL → delivered unchanged in order. Bypass build, empty queue, `enq_valid_i`=`deq_ready_i`=1 with PC 0x200 → `deq_pc_o`=0x200 in the same cycle and `count_o` stays 0.
